// File: rtl/axis_checker_pkg.sv
// ============================================================================
// Module      : axis_checker_pkg
// Description : Shared FSM state type and error codes for axis_stream_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ERROR   = 2'd2
    } state_e;

    localparam logic [2:0] c_ERR_NONE          = 3'd0;
    localparam logic [2:0] c_ERR_VALID_DROP    = 3'd1;
    localparam logic [2:0] c_ERR_DATA_CHANGE   = 3'd2;
    localparam logic [2:0] c_ERR_STALL_TIMEOUT = 3'd3;
    localparam logic [2:0] c_ERR_SEQ_MISMATCH  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sat_counter32.sv
// ============================================================================
// Module      : sat_counter32
// Description : 32-bit up counter with synchronous clear and enable; holds at
//               all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter32 (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 32'd0;
        end else if (en_i && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/axis_stream_checker.sv
// ============================================================================
// Module      : axis_stream_checker
// Description : Passive AXI-Stream protocol monitor: counts beats and stall
//               cycles and latches the first handshake-rule violation.
//               Optional sequence check: AXIS_STREAM_CHECKER_SEQ_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_stream_checker
    import axis_checker_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_STALL_CYCLES = 64,
    parameter int SEQ_START        = 0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  axis_tvalid_i,
    input  logic                  axis_tready_i,
    input  logic [DATA_WIDTH-1:0] axis_tdata_i,
    output logic [31:0]           beat_count_o,
    output logic [31:0]           stall_count_o,
    output logic                  error_o,
    output logic [2:0]            error_code_o,
    output logic [31:0]           error_beat_o
);

    // Timer holds at most MAX_STALL_CYCLES; the extra bit of the next value
    // lets it reach MAX_STALL_CYCLES+1 for the timeout compare.
    localparam int              TW            = $clog2(MAX_STALL_CYCLES + 2);
    localparam logic [TW:0]     c_TIMER_ONE   = (TW + 1)'(1);
    localparam logic [TW:0]     c_TIMER_LIMIT = (TW + 1)'(MAX_STALL_CYCLES);
    localparam logic [DATA_WIDTH-1:0] c_SEQ_INIT = DATA_WIDTH'(SEQ_START);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  error_q, error_d;
    logic [2:0]            code_q, code_d;
    logic [31:0]           ebeat_q, ebeat_d;

    logic                  w_hs;
    logic                  w_stall;
    logic                  w_seq_err;
    logic [TW:0]           w_timer_nxt;
    logic [2:0]            w_code;
    logic [31:0]           w_beat_count;
    logic [31:0]           w_stall_count;

    assign w_hs    = axis_tvalid_i & axis_tready_i;
    assign w_stall = axis_tvalid_i & ~axis_tready_i;

    sat_counter32 u_beat_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .en_i    (w_hs),
        .count_o (w_beat_count)
    );

    sat_counter32 u_stall_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .en_i    (w_stall),
        .count_o (w_stall_count)
    );

`ifdef AXIS_STREAM_CHECKER_SEQ_CHECK_EN
    logic [DATA_WIDTH-1:0] seq_q, seq_d;

    always_comb begin
        seq_d = seq_q;
        if (clear_i) begin
            seq_d = c_SEQ_INIT;
        end else if (w_hs) begin
            seq_d = seq_q + DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            seq_q <= c_SEQ_INIT;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign w_seq_err = w_hs && (axis_tdata_i != seq_q);
`else
    logic w_unused_seq;
    assign w_unused_seq = ^c_SEQ_INIT;
    assign w_seq_err    = 1'b0;
`endif

    // Error classification, highest priority first.
    always_comb begin
        w_timer_nxt = (state_q == ST_PENDING) ? ({1'b0, timer_q} + c_TIMER_ONE) : c_TIMER_ONE;
        w_code      = c_ERR_NONE;
        if (state_q == ST_PENDING) begin
            if (!axis_tvalid_i) begin
                w_code = c_ERR_VALID_DROP;
            end else if (axis_tdata_i != cap_q) begin
                w_code = c_ERR_DATA_CHANGE;
            end else if (w_stall && (w_timer_nxt > c_TIMER_LIMIT)) begin
                w_code = c_ERR_STALL_TIMEOUT;
            end
        end else if ((state_q == ST_IDLE) && w_stall && (w_timer_nxt > c_TIMER_LIMIT)) begin
            w_code = c_ERR_STALL_TIMEOUT;
        end
        if ((state_q != ST_ERROR) && (w_code == c_ERR_NONE) && w_seq_err) begin
            w_code = c_ERR_SEQ_MISMATCH;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        timer_d = timer_q;
        error_d = error_q;
        code_d  = code_q;
        ebeat_d = ebeat_q;
        if (clear_i) begin
            state_d = ST_IDLE;
            cap_d   = '0;
            timer_d = '0;
            error_d = 1'b0;
            code_d  = c_ERR_NONE;
            ebeat_d = 32'd0;
        end else if (w_code != c_ERR_NONE) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            code_d  = w_code;
            ebeat_d = w_beat_count;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_stall) begin
                        cap_d   = axis_tdata_i;
                        timer_d = c_TIMER_ONE[TW-1:0];
                        state_d = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_hs) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = w_timer_nxt[TW-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
            timer_q <= '0;
            error_q <= 1'b0;
            code_q  <= c_ERR_NONE;
            ebeat_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            timer_q <= timer_d;
            error_q <= error_d;
            code_q  <= code_d;
            ebeat_q <= ebeat_d;
        end
    end

    assign beat_count_o  = w_beat_count;
    assign stall_count_o = w_stall_count;
    assign error_o       = error_q;
    assign error_code_o  = code_q;
    assign error_beat_o  = ebeat_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_stream_checker.sv
// ============================================================================
// Module      : tb_axis_stream_checker
// Description : Self-checking bench for axis_stream_checker (two instances,
//               MAX_STALL_CYCLES 64 and 4, driven by the same link).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_stream_checker;

`ifdef AXIS_STREAM_CHECKER_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif
    localparam int MAXV [2] = '{64, 4};

    typedef struct packed {
        logic [31:0] beats;
        logic [31:0] stalls;
        logic        err;
        logic [2:0]  code;
        logic [31:0] ebeat;
    } obs_t;

    typedef struct {
        bit          v;
        bit          r;
        logic [31:0] d;
        bit          c;
        int          chk;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        tv;
    logic        tr;
    logic [31:0] td;

    logic [31:0] bc0, sc0, eb0, bc1, sc1, eb1;
    logic        er0, er1;
    logic [2:0]  ec0, ec1;
    obs_t        act0, act1;

    assign act0 = {bc0, sc0, er0, ec0, eb0};
    assign act1 = {bc1, sc1, er1, ec1, eb1};

    always #5 clk = ~clk;

    axis_stream_checker #(.DATA_WIDTH(32), .MAX_STALL_CYCLES(64), .SEQ_START(0)) dut0 (
        .clock_i(clk), .reset_i(rst_n), .clear_i(clr),
        .axis_tvalid_i(tv), .axis_tready_i(tr), .axis_tdata_i(td),
        .beat_count_o(bc0), .stall_count_o(sc0), .error_o(er0),
        .error_code_o(ec0), .error_beat_o(eb0)
    );

    axis_stream_checker #(.DATA_WIDTH(32), .MAX_STALL_CYCLES(4), .SEQ_START(0)) dut1 (
        .clock_i(clk), .reset_i(rst_n), .clear_i(clr),
        .axis_tvalid_i(tv), .axis_tready_i(tr), .axis_tdata_i(td),
        .beat_count_o(bc1), .stall_count_o(sc1), .error_o(er1),
        .error_code_o(ec1), .error_beat_o(eb1)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, one slot per instance (0 idle, 1 pending, 2 error)
    int          m_state  [2];
    logic [31:0] m_cap    [2];
    int          m_timer  [2];
    logic [31:0] m_seq    [2];
    obs_t        m_out    [2];
    obs_t        sb_q     [$];
    vec_t        vt       [$];

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got beats=%0d stalls=%0d err=%0b code=%0d ebeat=%0d, expected beats=%0d stalls=%0d err=%0b code=%0d ebeat=%0d",
                     name, act.beats, act.stalls, act.err, act.code, act.ebeat,
                     exp.beats, exp.stalls, exp.err, exp.code, exp.ebeat);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_cap[i]   = '0;
            m_timer[i] = 0;
            m_seq[i]   = 32'd0;
            m_out[i]   = '0;
        end
    endtask

    task automatic model_step(input int i, input bit v, input bit r, input logic [31:0] d, input bit c);
        bit       hs;
        bit       st;
        int       code;
        hs = v && r;
        st = v && !r;
        if (c) begin
            m_state[i] = 0;
            m_timer[i] = 0;
            m_seq[i]   = 32'd0;
            m_out[i]   = '0;
        end else begin
            code = 0;
            if (m_state[i] == 1) begin
                if (!v)                                 code = 1;
                else if (d != m_cap[i])                 code = 2;
                else if (st && (m_timer[i] + 1 > MAXV[i])) code = 3;
            end else if (m_state[i] == 0) begin
                if (st && (1 > MAXV[i]))                code = 3;
            end
            if (m_state[i] != 2 && code == 0 && SEQ_EN && hs && d != m_seq[i]) code = 4;

            if (code != 0) begin
                m_out[i].err   = 1'b1;
                m_out[i].code  = 3'(code);
                m_out[i].ebeat = m_out[i].beats;
                m_state[i]     = 2;
            end else if (m_state[i] == 0 && st) begin
                m_cap[i]   = d;
                m_timer[i] = 1;
                m_state[i] = 1;
            end else if (m_state[i] == 1) begin
                if (hs) m_state[i] = 0;
                else    m_timer[i] = m_timer[i] + 1;
            end
            if (hs) m_seq[i] = m_seq[i] + 32'd1;
            if (hs && m_out[i].beats != 32'hFFFF_FFFF) m_out[i].beats = m_out[i].beats + 32'd1;
            if (st && m_out[i].stalls != 32'hFFFF_FFFF) m_out[i].stalls = m_out[i].stalls + 32'd1;
        end
        sb_q.push_back(m_out[i]);
    endtask

    task automatic step(input bit v, input bit r, input logic [31:0] d, input bit c, input string tag);
        obs_t e0, e1;
        @(negedge clk);
        tv  = v;
        tr  = r;
        td  = d;
        clr = c;
        for (int i = 0; i < 2; i++) model_step(i, v, r, d, c);
        @(posedge clk);
        #1;
        e0 = sb_q.pop_front();
        e1 = sb_q.pop_front();
        check_obs({tag, "_sb0"}, act0, e0);
        check_obs({tag, "_sb1"}, act1, e1);
    endtask

    task automatic add(input bit v, input bit r, input logic [31:0] d, input bit c,
                       input int chk = -1, input logic [31:0] b = 0, input logic [31:0] s = 0,
                       input logic e = 0, input logic [2:0] code = 0, input logic [31:0] eb = 0);
        vec_t x;
        x.v   = v;
        x.r   = r;
        x.d   = d;
        x.c   = c;
        x.chk = chk;
        x.exp = {b, s, e, code, eb};
        vt.push_back(x);
    endtask

    initial begin
        obs_t zero;
        zero = '0;
        rst_n = 1'b0;
        clr   = 1'b0;
        tv    = 1'b0;
        tr    = 1'b0;
        td    = 32'd0;
        model_reset();

        // Ten back-to-back beats, then clear
        for (int i = 0; i < 10; i++) add(1, 1, 32'(i), 0, (i == 9) ? 0 : -1, 10, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // One beat stalled 5 cycles; small instance times out on the 5th
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 5, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // tvalid dropped after 2 stall cycles
        add(1, 0, 0, 0);
        add(1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
        add(0, 0, 0, 1);
        // 3 beats, then data change while stalled
        for (int i = 0; i < 3; i++) add(1, 1, 32'(i), 0);
        add(1, 0, 32'hA5, 0);
        add(1, 0, 32'h5A, 0, 0, 3, 2, 1, 2, 3);
        add(0, 0, 0, 1);
        // Six stall cycles with MAX_STALL_CYCLES=4, then clear
        for (int i = 0; i < 5; i++) add(1, 0, 7, 0);
        add(1, 0, 7, 0, 1, 0, 6, 1, 3, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // Sequence 0,1,2,4
        add(1, 1, 0, 0);
        add(1, 1, 1, 0);
        add(1, 1, 2, 0);
        if (SEQ_EN) add(1, 1, 4, 0, 0, 4, 0, 1, 4, 3);
        else        add(1, 1, 4, 0, 0, 4, 0, 0, 0, 0);
        add(0, 0, 0, 1);
        // Valid drop together with data change: drop wins; counters run in ERROR
        add(1, 0, 9, 0);
        add(0, 0, 3, 0, 0, 0, 1, 1, 1, 0);
        add(1, 1, 3, 0, 0, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1);
        // Clear beats a simultaneous handshake
        add(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        // Exactly MAX_STALL_CYCLES stalls on the small instance is legal
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1, 4, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_obs("reset_inst0", act0, zero);
        check_obs("reset_inst1", act1, zero);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < vt.size(); k++) begin
            step(vt[k].v, vt[k].r, vt[k].d, vt[k].c, $sformatf("vec%0d", k));
            if (vt[k].chk == 0)      check_obs($sformatf("vec%0d_inst0", k), act0, vt[k].exp);
            else if (vt[k].chk == 1) check_obs($sformatf("vec%0d_inst1", k), act1, vt[k].exp);
        end

        // Asynchronous reset in the middle of a stall
        step(1, 0, 1, 0, "midstall_a");
        step(1, 0, 1, 0, "midstall_b");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_obs("async_rst_inst0", act0, zero);
        check_obs("async_rst_inst1", act1, zero);
        @(negedge clk);
        tv    = 1'b0;
        tr    = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 1, 0, "post_rst_a");
        step(0, 0, 1, 0, "post_rst_b");
        step(1, 1, 0, 0, "post_rst_beat");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
